// File: rtl/dds_pkg.sv
// Shared definitions for the DDS tuning-word scheduler: default DDS
// accumulator width, default sample clock and the scheduler FSM encoding.
package dds_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int NUM_CH        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/dds_ftw_sched_if.sv
// Request/result bundle for the two-channel tuning-word scheduler.
// master = the client issuing frequency requests, slave = the scheduler.
interface dds_ftw_sched_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 ch0_req;
    logic [31:0]          ch0_freq;
    logic                 ch0_rdy;
    logic [ACC_WIDTH-1:0] ch0_ftw;
    logic                 ch0_vld;
    logic                 ch0_err;

    logic                 ch1_req;
    logic [31:0]          ch1_freq;
    logic                 ch1_rdy;
    logic [ACC_WIDTH-1:0] ch1_ftw;
    logic                 ch1_vld;
    logic                 ch1_err;

    logic                 busy;

    modport master (
        output ch0_req, ch0_freq, ch1_req, ch1_freq,
        input  ch0_rdy, ch0_ftw, ch0_vld, ch0_err,
        input  ch1_rdy, ch1_ftw, ch1_vld, ch1_err,
        input  busy
    );

    modport slave (
        input  ch0_req, ch0_freq, ch1_req, ch1_freq,
        output ch0_rdy, ch0_ftw, ch0_vld, ch0_err,
        output ch1_rdy, ch1_ftw, ch1_vld, ch1_err,
        output busy
    );
endinterface

// File: rtl/dds_ftw_sched_div.sv
// Purely combinational unsigned divider. Its operands come from registers
// held stable for several cycles, so the path is timed as a multicycle path.
module div_64_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int QUOT_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] numer,
    input  logic [DATA_WIDTH-1:0] denom,
    output logic [QUOT_WIDTH-1:0] quot
);
    // Guard against a zero denominator so the result is always defined.
    assign quot = (denom == '0) ? '0 : QUOT_WIDTH'(numer / denom);
endmodule

// File: rtl/dds_ftw_sched.sv
// Two-channel DDS frequency-tuning-word scheduler. Each channel queues one
// request; a round-robin FSM time-shares a single multicycle divider that
// computes round(freq * 2^ACC_WIDTH / CLK_FREQ).
module dds_ftw_sched
    import dds_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int CLK_FREQ    = CLK_FREQ_DEF,
    parameter int DIV_LATENCY = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    dds_ftw_sched_if.slave bus
);
    localparam logic [31:0]           NYQUIST  = 32'(CLK_FREQ / 2);
    localparam logic [DATA_WIDTH-1:0] DENOM    = DATA_WIDTH'(CLK_FREQ);
    localparam logic [DATA_WIDTH-1:0] HALF     = DATA_WIDTH'(CLK_FREQ / 2);
    localparam logic [3:0]            CNT_LOAD = 4'(DIV_LATENCY - 1);

    logic [NUM_CH-1:0]    req_w;
    logic [31:0]          freq_w    [NUM_CH];
    logic [NUM_CH-1:0]    pending_w;
    logic [31:0]          opnd_w    [NUM_CH];
    logic [ACC_WIDTH-1:0] ftw_w     [NUM_CH];
    logic [NUM_CH-1:0]    vld_w;
    logic [NUM_CH-1:0]    err_w;

    fsm_state_t           state_reg;
    logic [3:0]           cnt_reg;
    logic                 gnt_ch_reg;
    logic                 busy_reg;
    logic [DATA_WIDTH-1:0] numer_reg;
    logic [DATA_WIDTH-1:0] denom_reg;
    logic [ACC_WIDTH-1:0] quot_w;
    logic                 grant_w;
    logic                 grant_ch_w;

    assign req_w     = {bus.ch1_req, bus.ch0_req};
    assign freq_w[0] = bus.ch0_freq;
    assign freq_w[1] = bus.ch1_freq;

    assign bus.ch0_rdy = !pending_w[0];
    assign bus.ch1_rdy = !pending_w[1];
    assign bus.ch0_ftw = ftw_w[0];
    assign bus.ch1_ftw = ftw_w[1];
    assign bus.ch0_vld = vld_w[0];
    assign bus.ch1_vld = vld_w[1];
    assign bus.ch0_err = err_w[0];
    assign bus.ch1_err = err_w[1];
    assign bus.busy    = busy_reg;

    // Round-robin pick: on a tie the channel not served last wins.
    always_comb begin
        grant_w    = (state_reg == ST_IDLE) && (pending_w != '0);
        grant_ch_w = (pending_w == 2'b11) ? ~gnt_ch_reg : ~pending_w[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                 pending_reg;
            logic [31:0]          opnd_reg;
            logic [ACC_WIDTH-1:0] ftw_reg;
            logic                 vld_reg;
            logic                 err_reg;
            logic                 accept_w;
            logic                 in_range_w;
            logic                 mine_w;

            assign accept_w   = req_w[gi] && !pending_reg;
            assign in_range_w = (freq_w[gi] <= NYQUIST);
            assign mine_w     = (gnt_ch_reg == 1'(gi));

            // Request intake: queue in-range requests, flag out-of-range ones,
            // release the queue slot as soon as the FSM grants this channel.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    pending_reg <= 1'b0;
                    opnd_reg    <= '0;
                    err_reg     <= 1'b0;
                end else begin
                    err_reg <= accept_w && !in_range_w;
                    if (accept_w && in_range_w) begin
                        pending_reg <= 1'b1;
                        opnd_reg    <= freq_w[gi];
                    end else if (grant_w && (grant_ch_w == 1'(gi))) begin
                        pending_reg <= 1'b0;
                    end
                end
            end

            // Result capture: the quotient is taken when the FSM is in DONE.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    ftw_reg <= '0;
                    vld_reg <= 1'b0;
                end else begin
                    vld_reg <= (state_reg == ST_DONE) && mine_w;
                    if ((state_reg == ST_DONE) && mine_w) begin
                        ftw_reg <= quot_w;
                    end
                end
            end

            assign pending_w[gi] = pending_reg;
            assign opnd_w[gi]    = opnd_reg;
            assign ftw_w[gi]     = ftw_reg;
            assign vld_w[gi]     = vld_reg;
            assign err_w[gi]     = err_reg;
        end
    endgenerate

    // Scheduler FSM: grant, hold divider operands for DIV_LATENCY cycles, capture.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            gnt_ch_reg <= 1'b1;
            busy_reg   <= 1'b0;
            numer_reg  <= '0;
            denom_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_w) begin
                        gnt_ch_reg <= grant_ch_w;
                        numer_reg  <= (DATA_WIDTH'(opnd_w[grant_ch_w]) << ACC_WIDTH) + HALF;
                        denom_reg  <= DENOM;
                        cnt_reg    <= CNT_LOAD;
                        state_reg  <= ST_WAIT;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    div_64_64 #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUOT_WIDTH (ACC_WIDTH)
    ) div_64_64_inst (
        .numer (numer_reg),
        .denom (denom_reg),
        .quot  (quot_w)
    );

endmodule

// File: tb/tb_dds_ftw_sched.sv
// Bench for dds_ftw_sched: directed scenarios with literal expectations plus
// a long randomized run, all compared every cycle against a timing model that
// treats the divider as a shared resource busy for DIV_LATENCY+2 cycles.
module tb_dds_ftw_sched;
    localparam int              L    = 4;
    localparam longint unsigned FCLK = 50_000_000;

    logic sys_clk = 1'b0;
    logic sys_rst;
    bit   chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    dds_ftw_sched_if #(.ACC_WIDTH(32)) bus ();

    dds_ftw_sched #(
        .DATA_WIDTH  (64),
        .ACC_WIDTH   (32),
        .CLK_FREQ    (50_000_000),
        .DIV_LATENCY (L)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state
    bit          m_pend [2];
    logic [31:0] m_opnd [2];
    logic [31:0] m_ftw  [2];
    bit          m_vld  [2];
    bit          m_err  [2];
    bit          m_busy;
    bit          m_job;
    int          m_job_ch;
    int          m_rem;
    logic [31:0] m_res;
    int          m_last;

    function automatic logic [31:0] ftw_of(input logic [31:0] f);
        logic [63:0] n;
        n = ({32'd0, f} << 32) + 64'(FCLK / 2);
        return 32'(n / FCLK);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one request slot per channel, one shared divider job
    // whose result appears L+1 edges after the grant edge.
    always @(posedge sys_clk or posedge sys_rst) begin : model
        bit          old_pend [2];
        bit          req_s    [2];
        logic [31:0] f_s      [2];
        int          c;
        if (sys_rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 0; m_opnd[i] = '0; m_ftw[i] = '0; m_vld[i] = 0; m_err[i] = 0;
            end
            m_busy = 0; m_job = 0; m_job_ch = 0; m_rem = 0; m_res = '0; m_last = 1;
        end else begin
            req_s[0] = bus.ch0_req; f_s[0] = bus.ch0_freq;
            req_s[1] = bus.ch1_req; f_s[1] = bus.ch1_freq;
            old_pend = m_pend;
            for (int i = 0; i < 2; i++) begin
                m_vld[i] = 0; m_err[i] = 0;
            end
            if (m_job) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ftw[m_job_ch] = m_res;
                    m_vld[m_job_ch] = 1;
                    m_job = 0;
                end
            end else if (old_pend[0] || old_pend[1]) begin
                if (old_pend[0] && old_pend[1]) c = (m_last == 0) ? 1 : 0;
                else                            c = old_pend[0] ? 0 : 1;
                m_job = 1; m_job_ch = c; m_rem = L + 1;
                m_res = ftw_of(m_opnd[c]);
                m_pend[c] = 0; m_last = c;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_s[i] && !old_pend[i]) begin
                    if (longint'(f_s[i]) > longint'(FCLK / 2)) m_err[i] = 1;
                    else begin
                        m_pend[i] = 1; m_opnd[i] = f_s[i];
                    end
                end
            end
            m_busy = m_job;
        end
    end

    // Compare process: every DUT output against the model on every cycle.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("ch0_rdy", 64'(bus.ch0_rdy), 64'(!m_pend[0]));
            chk("ch1_rdy", 64'(bus.ch1_rdy), 64'(!m_pend[1]));
            chk("ch0_ftw", 64'(bus.ch0_ftw), 64'(m_ftw[0]));
            chk("ch1_ftw", 64'(bus.ch1_ftw), 64'(m_ftw[1]));
            chk("ch0_vld", 64'(bus.ch0_vld), 64'(m_vld[0]));
            chk("ch1_vld", 64'(bus.ch1_vld), 64'(m_vld[1]));
            chk("ch0_err", 64'(bus.ch0_err), 64'(m_err[0]));
            chk("ch1_err", 64'(bus.ch1_err), 64'(m_err[1]));
            chk("busy",    64'(bus.busy),    64'(m_busy));
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int ch, input bit r, input logic [31:0] f);
        if (ch == 0) begin bus.ch0_req = r; bus.ch0_freq = f; end
        else         begin bus.ch1_req = r; bus.ch1_freq = f; end
    endtask

    function automatic bit vld_of(input int ch);
        return (ch == 0) ? bus.ch0_vld : bus.ch1_vld;
    endfunction

    // Present a request for one clock edge; returns just after that edge.
    task automatic send(input int ch, input logic [31:0] f);
        set_req(ch, 1'b1, f);
        tick();
        set_req(ch, 1'b0, f);
    endtask

    task automatic wait_vld(input int ch, output int n);
        n = 0;
        while (!vld_of(ch) && n < 30) begin
            tick();
            n++;
        end
        if (!vld_of(ch)) n = -1;
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, n1, cnt;
        logic [31:0] f;
        sys_rst = 1'b1;
        bus.ch0_req = 0; bus.ch0_freq = '0;
        bus.ch1_req = 0; bus.ch1_freq = '0;
        @(posedge sys_clk);
        chk_en = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;

        // Reset values
        chk("rst_rdy0", 64'(bus.ch0_rdy), 64'd1);
        chk("rst_rdy1", 64'(bus.ch1_rdy), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ftw0", 64'(bus.ch0_ftw), 64'd0);
        tick();

        // 1 MHz on ch0: result after edge E+6
        send(0, 32'd1_000_000);
        wait_vld(0, n);
        chk("lat_1M", 64'(n), 64'd6);
        chk("ftw_1M", 64'(bus.ch0_ftw), 64'd85_899_346);
        tick();

        // Nyquist exactly, then one above
        send(1, 32'd25_000_000);
        wait_vld(1, n);
        chk("ftw_nyq", 64'(bus.ch1_ftw), 64'd2_147_483_648);
        tick();
        send(1, 32'd25_000_001);
        chk("err_pulse", 64'(bus.ch1_err), 64'd1);
        chk("err_busy", 64'(bus.busy), 64'd0);
        chk("err_ftw", 64'(bus.ch1_ftw), 64'd2_147_483_648);
        tick();
        chk("err_clear", 64'(bus.ch1_err), 64'd0);

        // Smallest frequencies
        send(0, 32'd0);
        wait_vld(0, n);
        chk("ftw_0", 64'(bus.ch0_ftw), 64'd0);
        tick();
        send(0, 32'd1);
        wait_vld(0, n);
        chk("ftw_1", 64'(bus.ch0_ftw), 64'd86);
        tick();

        // Tie right after reset: ch0 first, ch1 one slot later
        pulse_reset();
        set_req(0, 1'b1, 32'd1_000_000);
        set_req(1, 1'b1, 32'd25_000_000);
        tick();
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        wait_vld(0, n);
        chk("tie_ch0_lat", 64'(n), 64'd6);
        wait_vld(1, n1);
        chk("tie_ch1_gap", 64'(n1), 64'(L + 2));
        chk("tie_ch1_ftw", 64'(bus.ch1_ftw), 64'd2_147_483_648);
        tick();

        // Second ch0 request queued while the first one computes
        send(0, 32'd1_000_000);
        tick();
        send(0, 32'd3_000_000);
        chk("queue_rdy", 64'(bus.ch0_rdy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ch0_vld) cnt++;
        end
        chk("queue_pulses", 64'(cnt), 64'd2);
        chk("queue_ftw", 64'(bus.ch0_ftw), 64'd257_698_038);

        // Reset during WAIT drops the in-flight result
        send(0, 32'd1_000_000);
        tick();
        tick();
        pulse_reset();
        chk("mid_rst_ftw0", 64'(bus.ch0_ftw), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ch0_vld) cnt++;
        end
        chk("mid_rst_novld", 64'(cnt), 64'd0);
        send(0, 32'd25_000_000);
        wait_vld(0, n);
        chk("post_rst_lat", 64'(n), 64'd6);
        chk("post_rst_ftw", 64'(bus.ch0_ftw), 64'd2_147_483_648);

        // Randomized traffic; the compare process checks every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end
            for (int ch = 0; ch < 2; ch++) begin
                case ($urandom_range(0, 5))
                    0:       f = 32'd0;
                    1:       f = 32'd1;
                    2:       f = 32'd25_000_000;
                    3:       f = 32'd25_000_001;
                    4:       f = 32'($urandom_range(0, 25_000_000));
                    default: f = $urandom;
                endcase
                set_req(ch, ($urandom_range(0, 3) == 0), f);
            end
        end
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_ftw_sched.md
DDS_FTW_SCHED -- requirements
Module: dds_ftw_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 64: divider operand width.
REQ-002 Parameter ACC_WIDTH, default 32: DDS phase-accumulator width; FTW width.
REQ-003 Parameter CLK_FREQ, default 50_000_000: DDS sample clock in Hz; divider denominator.
REQ-004 Parameter DIV_LATENCY, default 4 (legal range 1..15): cycles the divider operands are held stable before sampling.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 sys_clk  in  1  system clock; all state on rising edge.
REQ-007 sys_rst  in  1  asynchronous active-high reset.
REQ-008 chN_req  in  1  (N=0,1) request strobe; accepted on an edge where chN_req && chN_rdy.
REQ-009 chN_freq  in  32  (N=0,1) requested output frequency in Hz, sampled on accept.
REQ-010 chN_rdy  out  1  (N=0,1) channel can accept; equals !pending_N.
REQ-011 chN_ftw  out  ACC_WIDTH  (N=0,1) last computed tuning word, held until the next result.
REQ-012 chN_vld  out  1  (N=0,1) one-cycle pulse: chN_ftw updated.
REQ-013 chN_err  out  1  (N=0,1) one-cycle pulse: request rejected, freq above Nyquist.
REQ-014 busy  out  1  high while the FSM is not IDLE.

Function
REQ-015 FTW = floor(((freq << ACC_WIDTH) + CLK_FREQ/2) / CLK_FREQ), i.e. round-to-nearest; numerator built zero-extended to DATA_WIDTH bits.
REQ-016 Accepted freq > CLK_FREQ/2: pending not set, divider unused, chN_err pulses in the cycle after the accept edge, chN_ftw unchanged.
REQ-017 Accepted freq <= CLK_FREQ/2: pending_N set on the accept edge, operand latched.
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 IDLE: on an edge with any pending, grant one channel, clear its pending, register numer/denom, load cnt = DIV_LATENCY-1, go WAIT.
REQ-020 WAIT: cnt != 0 -> decrement; cnt == 0 -> go DONE.
REQ-021 DONE: capture quotient[ACC_WIDTH-1:0] into granted chN_ftw, pulse chN_vld the following cycle, go IDLE; no grant on this edge.
REQ-022 Latency: accept edge E -> chN_vld high in the cycle after edge E+DIV_LATENCY+2 when the FSM is idle; throughput one result per DIV_LATENCY+2 cycles.
REQ-023 Arbitration round-robin: both pending in IDLE -> grant the channel not granted last; single pending -> grant it.
REQ-024 Since pending clears at grant, a channel may queue one new request while its previous one computes; results are delivered in order.
REQ-025 Divider operands are stable from the grant edge through the DONE edge.
REQ-026 Accept and grant for different channels on the same edge are both honoured.

Reset
REQ-027 sys_rst asserted: FSM IDLE, pending cleared, cnt 0, RR pointer = ch1 (so ch0 wins the first tie), chN_ftw 0, chN_vld 0, chN_err 0, busy 0, chN_rdy 1.
REQ-028 Reset mid-computation discards the in-flight result; no vld is produced for it after release.

Structure
REQ-029 Shared package dds_pkg holds ACC_WIDTH, CLK_FREQ defaults and the FSM state encoding.
REQ-030 Single sub-module: div_64_64_inst (DATA_WIDTH=64, combinational), driven from registered operands and constrained as a DIV_LATENCY-cycle multicycle path.

Verification
REQ-031 ch0 freq=1_000_000, DIV_LATENCY=4, idle FSM -> ch0_ftw=85_899_346, ch0_vld after edge E+6.
REQ-032 ch1 freq=25_000_000 -> ch1_ftw=2_147_483_648; freq=25_000_001 -> ch1_err pulse, ch1_ftw unchanged, busy stays 0.
REQ-033 freq=0 -> ftw 0; freq=1 -> ftw 86.
REQ-034 ch0 and ch1 accepted on the same edge after reset -> ch0 result first, ch1 DIV_LATENCY+2 cycles later; repeated ties alternate.
REQ-035 ch0 second request accepted during its WAIT -> ch0_rdy low until the second grant, two ch0_vld pulses, final ch0_ftw from the second request.
REQ-036 sys_rst pulsed during WAIT -> all outputs at reset values, no vld; new request afterwards completes normally.
